// File: rtl/router_fsm_pkg.sv
// Shared router types: controller state enumeration and header address constants.
// Three output ports addressed by a 2-bit header field; the fourth code is reserved.
package router_fsm_pkg;

    localparam int NUM_PORTS = 3;

    typedef logic [1:0] addr_t;

    localparam addr_t PORT0        = 2'b00;
    localparam addr_t PORT1        = 2'b01;
    localparam addr_t PORT2        = 2'b10;
    localparam addr_t ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {
        DECODE_ADDRESS,
        LOAD_FIRST_DATA,
        LOAD_DATA,
        WAIT_TILL_EMPTY,
        FIFO_FULL_STATE,
        LOAD_AFTER_FULL,
        LOAD_PARITY,
        CHECK_PARITY_ERROR
    } state_t;

endpackage

// File: rtl/router_fsm_if.sv
// Controller <-> register block / output FIFO signal bundle; master is the FSM side.
// Strobes are registered-state decodes, so the slave side sees them one cycle after its inputs.
interface router_fsm_if;
    import router_fsm_pkg::*;

    logic  pkt_valid;
    addr_t data_in;
    logic  fifo_full;
    logic  fifo_empty_0;
    logic  fifo_empty_1;
    logic  fifo_empty_2;
    logic  soft_reset_0;
    logic  soft_reset_1;
    logic  soft_reset_2;
    logic  parity_done;
    logic  low_pkt_valid;

    logic  detect_add;
    logic  lfd_state;
    logic  ld_state;
    logic  laf_state;
    logic  full_state;
    logic  rst_int_reg;
    logic  write_enb_reg;
    logic  busy;

    modport master (
        input  pkt_valid, data_in, fifo_full,
        input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
        input  soft_reset_0, soft_reset_1, soft_reset_2,
        input  parity_done, low_pkt_valid,
        output detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
        output write_enb_reg, busy
    );

    modport slave (
        output pkt_valid, data_in, fifo_full,
        output fifo_empty_0, fifo_empty_1, fifo_empty_2,
        output soft_reset_0, soft_reset_1, soft_reset_2,
        output parity_done, low_pkt_valid,
        input  detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
        input  write_enb_reg, busy
    );

endinterface

// File: rtl/router_fsm.sv
// Router packet-load controller: Moore FSM, outputs follow the registered state (1-cycle latency).
// busy asks the source to hold its byte whenever the FSM is not decoding or streaming payload.
module router_fsm
    import router_fsm_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    router_fsm_if.master  bus
);

    state_t state_q, state_d;
    addr_t  addr_q,  addr_d;

    // Reserved address slot stays 0 so indexing by any 2-bit code is defined.
    logic [NUM_PORTS:0] empty_vec;
    logic [NUM_PORTS:0] soft_vec;

    always_comb begin
        empty_vec               = '0;
        soft_vec                = '0;
        empty_vec[PORT0]        = bus.fifo_empty_0;
        empty_vec[PORT1]        = bus.fifo_empty_1;
        empty_vec[PORT2]        = bus.fifo_empty_2;
        empty_vec[ADDR_INVALID] = 1'b0;
        soft_vec[PORT0]         = bus.soft_reset_0;
        soft_vec[PORT1]         = bus.soft_reset_1;
        soft_vec[PORT2]         = bus.soft_reset_2;
        soft_vec[ADDR_INVALID]  = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= DECODE_ADDRESS;
            addr_q  <= PORT0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        unique case (state_q)
            DECODE_ADDRESS: begin
                if (bus.pkt_valid && (bus.data_in != ADDR_INVALID)) begin
                    addr_d  = bus.data_in;
                    state_d = empty_vec[bus.data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
            end
            LOAD_FIRST_DATA: state_d = LOAD_DATA;
            LOAD_DATA: begin
                if (bus.fifo_full)       state_d = FIFO_FULL_STATE;
                else if (!bus.pkt_valid) state_d = LOAD_PARITY;
            end
            WAIT_TILL_EMPTY: begin
                if (empty_vec[addr_q]) state_d = LOAD_FIRST_DATA;
            end
            FIFO_FULL_STATE: begin
                if (!bus.fifo_full) state_d = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (bus.parity_done)        state_d = DECODE_ADDRESS;
                else if (bus.low_pkt_valid) state_d = LOAD_PARITY;
                else                        state_d = LOAD_DATA;
            end
            LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: state_d = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            default: state_d = DECODE_ADDRESS;
        endcase

        // A read timeout on the port being loaded abandons the packet.
        if ((state_q != DECODE_ADDRESS) && soft_vec[addr_q]) begin
            state_d = DECODE_ADDRESS;
        end
    end

    always_comb begin
        bus.detect_add    = 1'b0;
        bus.lfd_state     = 1'b0;
        bus.ld_state      = 1'b0;
        bus.laf_state     = 1'b0;
        bus.full_state    = 1'b0;
        bus.rst_int_reg   = 1'b0;
        bus.write_enb_reg = 1'b0;
        bus.busy          = 1'b1;
        unique case (state_q)
            DECODE_ADDRESS: begin
                bus.detect_add = 1'b1;
                bus.busy       = 1'b0;
            end
            LOAD_FIRST_DATA: bus.lfd_state = 1'b1;
            LOAD_DATA: begin
                bus.ld_state      = 1'b1;
                bus.write_enb_reg = 1'b1;
                bus.busy          = 1'b0;
            end
            WAIT_TILL_EMPTY: ;
            FIFO_FULL_STATE: bus.full_state = 1'b1;
            LOAD_AFTER_FULL: begin
                bus.laf_state     = 1'b1;
                bus.write_enb_reg = 1'b1;
            end
            LOAD_PARITY: bus.write_enb_reg = 1'b1;
            CHECK_PARITY_ERROR: bus.rst_int_reg = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_router_fsm.sv
// Directed bench for router_fsm: a per-cycle reference model plus literal per-step expectations.
module tb_router_fsm;

    logic clock;
    logic reset;
    router_fsm_if bus();

    router_fsm dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int checks   = 0;
    int failures = 0;

    // Output vector order: {detect_add, lfd, ld, laf, full, rst_int, write_enb, busy}
    localparam logic [7:0] O_DA  = 8'h80;
    localparam logic [7:0] O_LFD = 8'h41;
    localparam logic [7:0] O_LD  = 8'h22;
    localparam logic [7:0] O_LAF = 8'h13;
    localparam logic [7:0] O_FUL = 8'h09;
    localparam logic [7:0] O_LP  = 8'h03;
    localparam logic [7:0] O_CPE = 8'h05;
    localparam logic [7:0] O_WTE = 8'h01;

    // Model phases are named by the packet activity, not by any RTL encoding.
    localparam int M_IDLE = 0, M_FIRST = 1, M_BODY = 2, M_WAIT = 3,
                   M_STALL = 4, M_RESUME = 5, M_PAR = 6, M_CHK = 7;

    int       m_phase;
    int       m_port;
    logic     cmp_en = 1'b0;

    function automatic logic [7:0] phase_outs(input int p);
        case (p)
            M_IDLE:   return O_DA;
            M_FIRST:  return O_LFD;
            M_BODY:   return O_LD;
            M_WAIT:   return O_WTE;
            M_STALL:  return O_FUL;
            M_RESUME: return O_LAF;
            M_PAR:    return O_LP;
            default:  return O_CPE;
        endcase
    endfunction

    function automatic logic port_empty(input int p);
        return (p == 0) ? bus.fifo_empty_0 : (p == 1) ? bus.fifo_empty_1 : bus.fifo_empty_2;
    endfunction

    function automatic logic port_soft(input int p);
        return (p == 0) ? bus.soft_reset_0 : (p == 1) ? bus.soft_reset_1 : bus.soft_reset_2;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_phase <= M_IDLE;
            m_port  <= 0;
        end else if (m_phase != M_IDLE && port_soft(m_port)) begin
            m_phase <= M_IDLE;
        end else if (m_phase == M_IDLE) begin
            if (bus.pkt_valid && int'(bus.data_in) < 3) begin
                m_port  <= int'(bus.data_in);
                m_phase <= port_empty(int'(bus.data_in)) ? M_FIRST : M_WAIT;
            end
        end else if (m_phase == M_FIRST) m_phase <= M_BODY;
        else if (m_phase == M_BODY) begin
            if (bus.fifo_full)       m_phase <= M_STALL;
            else if (!bus.pkt_valid) m_phase <= M_PAR;
        end else if (m_phase == M_WAIT) begin
            if (port_empty(m_port)) m_phase <= M_FIRST;
        end else if (m_phase == M_STALL) begin
            if (!bus.fifo_full) m_phase <= M_RESUME;
        end else if (m_phase == M_RESUME) begin
            m_phase <= bus.parity_done ? M_IDLE : bus.low_pkt_valid ? M_PAR : M_BODY;
        end else if (m_phase == M_PAR) m_phase <= M_CHK;
        else m_phase <= bus.fifo_full ? M_STALL : M_IDLE;
    end

    logic [7:0] dut_outs;
    assign dut_outs = {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state,
                       bus.full_state, bus.rst_int_reg, bus.write_enb_reg, bus.busy};

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (cmp_en) chk("model", dut_outs, phase_outs(m_phase));
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset            = 1'b1;
        bus.pkt_valid    = 1'b0;
        bus.data_in      = 2'b00;
        bus.fifo_full    = 1'b0;
        bus.fifo_empty_0 = 1'b0;
        bus.fifo_empty_1 = 1'b0;
        bus.fifo_empty_2 = 1'b0;
        bus.soft_reset_0 = 1'b0;
        bus.soft_reset_1 = 1'b0;
        bus.soft_reset_2 = 1'b0;
        bus.parity_done  = 1'b0;
        bus.low_pkt_valid = 1'b0;
        step(); step();
        reset  = 1'b0;
        cmp_en = 1'b1;
        chk("reset_state", dut_outs, O_DA);

        // Port 1 header with empty FIFO
        bus.pkt_valid = 1'b1; bus.data_in = 2'b01; bus.fifo_empty_1 = 1'b1;
        step(); chk("p1_lfd", dut_outs, O_LFD);
        step(); chk("p1_ld", dut_outs, O_LD);

        // Three full cycles, resume, early pkt_valid drop
        bus.fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); chk("p1_full", dut_outs, O_FUL);
        end
        bus.fifo_full = 1'b0;
        step(); chk("p1_laf", dut_outs, O_LAF);
        bus.low_pkt_valid = 1'b1;
        step(); chk("p1_lp", dut_outs, O_LP);
        bus.low_pkt_valid = 1'b0; bus.pkt_valid = 1'b0;
        step(); chk("p1_cpe", dut_outs, O_CPE);
        step(); chk("p1_da", dut_outs, O_DA);
        step(); chk("idle_hold", dut_outs, O_DA);

        // Port 2 busy FIFO: wait ignores other ports' flags and soft resets
        bus.pkt_valid = 1'b1; bus.data_in = 2'b10; bus.fifo_empty_2 = 1'b0;
        step(); chk("p2_wait0", dut_outs, O_WTE);
        bus.fifo_empty_0 = 1'b1; bus.soft_reset_1 = 1'b1;
        for (int i = 1; i < 5; i++) begin
            step(); chk("p2_wait", dut_outs, O_WTE);
        end
        bus.soft_reset_1 = 1'b0; bus.fifo_empty_2 = 1'b1;
        step(); chk("p2_lfd", dut_outs, O_LFD);
        step(); chk("p2_ld", dut_outs, O_LD);
        bus.pkt_valid = 1'b0;
        step(); chk("p2_lp", dut_outs, O_LP);
        step(); chk("p2_cpe", dut_outs, O_CPE);
        step(); chk("p2_da", dut_outs, O_DA);

        // Invalid address is never accepted
        bus.pkt_valid = 1'b1; bus.data_in = 2'b11;
        step(); chk("inv_da0", dut_outs, O_DA);
        step(); chk("inv_da1", dut_outs, O_DA);

        // Port 0: soft reset ignored in decode, other port ignored, own port aborts
        bus.data_in = 2'b00; bus.soft_reset_0 = 1'b1;
        step(); chk("p0_lfd", dut_outs, O_LFD);
        bus.soft_reset_0 = 1'b0;
        step(); chk("p0_ld", dut_outs, O_LD);
        bus.soft_reset_1 = 1'b1;
        step(); chk("p0_sr1", dut_outs, O_LD);
        bus.soft_reset_1 = 1'b0; bus.soft_reset_0 = 1'b1;
        step(); chk("p0_sr0", dut_outs, O_DA);
        bus.soft_reset_0 = 1'b0;

        // Port 1: full beats end-of-packet, LAF->LD, CPE->FULL, LAF parity_done->DA
        bus.data_in = 2'b01;
        step(); chk("q_lfd", dut_outs, O_LFD);
        step(); chk("q_ld", dut_outs, O_LD);
        bus.fifo_full = 1'b1; bus.pkt_valid = 1'b0;
        step(); chk("q_full_prio", dut_outs, O_FUL);
        bus.fifo_full = 1'b0;
        step(); chk("q_laf", dut_outs, O_LAF);
        step(); chk("q_laf_ld", dut_outs, O_LD);
        step(); chk("q_lp", dut_outs, O_LP);
        bus.fifo_full = 1'b1;
        step(); chk("q_cpe", dut_outs, O_CPE);
        step(); chk("q_cpe_full", dut_outs, O_FUL);
        bus.fifo_full = 1'b0; bus.parity_done = 1'b1;
        step(); chk("q_laf2", dut_outs, O_LAF);
        step(); chk("q_pd_da", dut_outs, O_DA);
        bus.parity_done = 1'b0;

        // Reset in FIFO_FULL_STATE wins over soft reset and transitions
        bus.pkt_valid = 1'b1; bus.data_in = 2'b00;
        step(); chk("r_lfd", dut_outs, O_LFD);
        step(); chk("r_ld", dut_outs, O_LD);
        bus.fifo_full = 1'b1;
        step(); chk("r_full", dut_outs, O_FUL);
        reset = 1'b1; bus.soft_reset_0 = 1'b1; bus.fifo_full = 1'b0;
        step(); chk("r_da", dut_outs, O_DA);
        reset = 1'b0; bus.soft_reset_0 = 1'b0; bus.pkt_valid = 1'b0;
        step(); chk("r_hold", dut_outs, O_DA);

        // Reset mid-packet on port 2 abandons it
        bus.pkt_valid = 1'b1; bus.data_in = 2'b10;
        step(); chk("r2_lfd", dut_outs, O_LFD);
        step(); chk("r2_ld", dut_outs, O_LD);
        reset = 1'b1; bus.soft_reset_2 = 1'b1;
        step(); chk("r2_da", dut_outs, O_DA);
        reset = 1'b0; bus.soft_reset_2 = 1'b0; bus.pkt_valid = 1'b0;
        step(); step();
        cmp_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
